// File: rtl/weight_loader_pkg.sv
// Shared types and constants for the BRAM-to-register weight loader.
package weight_loader_pkg;

  localparam logic [1:0] WL_S_IDLE  = 2'b00;
  localparam logic [1:0] WL_S_READ  = 2'b01;
  localparam logic [1:0] WL_S_DRAIN = 2'b10;
  localparam logic [1:0] WL_S_DONE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = WL_S_IDLE,
    ST_READ  = WL_S_READ,
    ST_DRAIN = WL_S_DRAIN,
    ST_DONE  = WL_S_DONE
  } wl_state_t;

  localparam int WL_DEF_W          = 8;
  localparam int WL_DEF_ADDR_WIDTH = 18;
  localparam int WL_MAX_RD_LATENCY = 4;

endpackage

// File: rtl/rd_valid_pipe.sv
// Valid-bit shift register matching the BRAM read latency; its output marks
// the cycle in which mem_dout carries the word for an earlier issued read.
module rd_valid_pipe
  import weight_loader_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_flush,
  input  logic i_valid,
  output logic o_valid
);

  logic [RD_LATENCY-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_valid;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_valid = r_pipe[RD_LATENCY-1];

endmodule

// File: rtl/weight_loader_stream.sv
// Loads TOTAL_WEIGHTS consecutive BRAM words from a runtime base address into a
// flat weight bus. Define WEIGHT_LOADER_STREAM_EN to add the per-word stream outputs.
module weight_loader_stream
  import weight_loader_pkg::*;
#(
  parameter  int IN_SIZE       = 1152,
  parameter  int OUT_SIZE      = 8,
  parameter  int W             = WL_DEF_W,
  parameter  int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE,
  parameter  int ADDR_WIDTH    = WL_DEF_ADDR_WIDTH,
  parameter  int RD_LATENCY    = 2,
  localparam int CW            = $clog2(TOTAL_WEIGHTS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  output logic                       mem_en,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic [W-1:0]               mem_dout,
  output logic [TOTAL_WEIGHTS*W-1:0] data_out,
  output logic                       busy,
  output logic                       done
`ifdef WEIGHT_LOADER_STREAM_EN
  ,
  output logic                       w_valid,
  output logic [W-1:0]               w_data,
  output logic [CW-1:0]              w_index
`endif
);

  localparam logic [CW-1:0] TW_C    = CW'(TOTAL_WEIGHTS);
  localparam logic [CW-1:0] TW_LAST = CW'(TOTAL_WEIGHTS - 1);

  wl_state_t                  r_state;
  wl_state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]      r_base;
  logic [ADDR_WIDTH-1:0]      r_mem_addr;
  logic                       r_mem_en;
  logic [CW-1:0]              r_issued;
  logic [CW-1:0]              r_captured;
  logic [TOTAL_WEIGHTS*W-1:0] r_data;
  logic                       w_accept;
  logic                       w_issue_end;
  logic                       w_cap;
  logic                       w_cap_last;

  rd_valid_pipe #(.RD_LATENCY(RD_LATENCY)) u_vpipe (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_accept),
    .i_valid (r_mem_en),
    .o_valid (w_cap)
  );

  assign w_cap_last = w_cap && (r_captured == TW_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue_end = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_READ;
          w_accept    = 1'b1;
        end
      end
      ST_READ: begin
        if (r_issued == TW_C) begin
          w_state_nxt = ST_DRAIN;
          w_issue_end = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_cap_last) w_state_nxt = ST_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Issue side: r_issued counts reads already presented, so the first
  // address goes out directly from the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base     <= '0;
      r_mem_addr <= '0;
      r_mem_en   <= 1'b0;
      r_issued   <= '0;
      r_captured <= '0;
    end else if (w_accept) begin
      r_base     <= base_addr;
      r_mem_addr <= base_addr;
      r_mem_en   <= 1'b1;
      r_issued   <= CW'(1);
      r_captured <= '0;
    end else begin
      if (r_state == ST_READ) begin
        if (w_issue_end) begin
          r_mem_en <= 1'b0;
        end else begin
          r_mem_addr <= r_base + ADDR_WIDTH'(r_issued);
          r_issued   <= r_issued + 1'b1;
        end
      end
      if (w_cap) r_captured <= r_captured + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        r_data <= '0;
    else if (w_cap) r_data[r_captured*W +: W] <= mem_dout;
  end

`ifdef WEIGHT_LOADER_STREAM_EN
  logic          r_w_valid;
  logic [W-1:0]  r_w_data;
  logic [CW-1:0] r_w_index;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_valid <= 1'b0;
      r_w_data  <= '0;
      r_w_index <= '0;
    end else begin
      r_w_valid <= w_cap;
      if (w_cap) begin
        r_w_data  <= mem_dout;
        r_w_index <= r_captured;
      end
    end
  end

  assign w_valid = r_w_valid;
  assign w_data  = r_w_data;
  assign w_index = r_w_index;
`endif

  assign mem_en   = r_mem_en;
  assign mem_addr = r_mem_addr;
  assign data_out = r_data;
  assign busy     = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_weight_loader_stream.sv
// Bench for weight_loader_stream: four instances (latency 1/2/4 with 4 words,
// and a 7-word, 6-bit-address instance for randomized runs).
module tb_weight_loader_stream;

  localparam int TR = 7;
  localparam int LR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_r = 1'b0;
  logic [17:0] base = '0;
  logic [5:0]  base_r = '0;
  logic [7:0]  salt = '0;

  logic        en_a, en_b, en_c, en_r;
  logic [17:0] addr_a, addr_b, addr_c;
  logic [5:0]  addr_r;
  logic [7:0]  dout_a, dout_b, dout_c, dout_r;
  logic [31:0] data_a, data_b, data_c;
  logic [55:0] data_r;
  logic        busy_a, busy_b, busy_c, busy_r;
  logic        done_a, done_b, done_c, done_r;
`ifdef WEIGHT_LOADER_STREAM_EN
  logic        sv_a, sv_b, sv_c, sv_r;
  logic [7:0]  sd_a, sd_b, sd_c, sd_r;
  logic [2:0]  si_a, si_b, si_c, si_r;
`endif

  weight_loader_stream #(.IN_SIZE(4), .OUT_SIZE(1), .W(8), .TOTAL_WEIGHTS(4),
                         .ADDR_WIDTH(18), .RD_LATENCY(2)) u_a (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .mem_en(en_a),
    .mem_addr(addr_a), .mem_dout(dout_a), .data_out(data_a), .busy(busy_a), .done(done_a)
`ifdef WEIGHT_LOADER_STREAM_EN
    , .w_valid(sv_a), .w_data(sd_a), .w_index(si_a)
`endif
  );
  weight_loader_stream #(.IN_SIZE(4), .OUT_SIZE(1), .W(8), .TOTAL_WEIGHTS(4),
                         .ADDR_WIDTH(18), .RD_LATENCY(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .mem_en(en_b),
    .mem_addr(addr_b), .mem_dout(dout_b), .data_out(data_b), .busy(busy_b), .done(done_b)
`ifdef WEIGHT_LOADER_STREAM_EN
    , .w_valid(sv_b), .w_data(sd_b), .w_index(si_b)
`endif
  );
  weight_loader_stream #(.IN_SIZE(4), .OUT_SIZE(1), .W(8), .TOTAL_WEIGHTS(4),
                         .ADDR_WIDTH(18), .RD_LATENCY(4)) u_c (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .mem_en(en_c),
    .mem_addr(addr_c), .mem_dout(dout_c), .data_out(data_c), .busy(busy_c), .done(done_c)
`ifdef WEIGHT_LOADER_STREAM_EN
    , .w_valid(sv_c), .w_data(sd_c), .w_index(si_c)
`endif
  );
  weight_loader_stream #(.IN_SIZE(TR), .OUT_SIZE(1), .W(8), .TOTAL_WEIGHTS(TR),
                         .ADDR_WIDTH(6), .RD_LATENCY(LR)) u_r (
    .clk(clk), .rst(rst), .start(start_r), .base_addr(base_r), .mem_en(en_r),
    .mem_addr(addr_r), .mem_dout(dout_r), .data_out(data_r), .busy(busy_r), .done(done_r)
`ifdef WEIGHT_LOADER_STREAM_EN
    , .w_valid(sv_r), .w_data(sd_r), .w_index(si_r)
`endif
  );

  function automatic logic [7:0] f_r(input logic [5:0] a, input logic [7:0] s);
    return ({2'b00, a} * 8'd37) ^ s;
  endfunction

  // BRAM models: data for an address appears RD_LATENCY cycles later; junk otherwise.
  logic [7:0] pa [2];
  logic [7:0] pb;
  logic [7:0] pc [4];
  logic [7:0] pr [3];
  always @(posedge clk) begin
    pa[0] <= en_a ? addr_a[7:0] : 8'($urandom);
    pa[1] <= pa[0];
    pb    <= en_b ? addr_b[7:0] : 8'($urandom);
    pc[0] <= en_c ? addr_c[7:0] : 8'($urandom);
    pc[1] <= pc[0];
    pc[2] <= pc[1];
    pc[3] <= pc[2];
    pr[0] <= en_r ? f_r(addr_r, salt) : 8'($urandom);
    pr[1] <= pr[0];
    pr[2] <= pr[1];
  end
  assign dout_a = pa[1];
  assign dout_b = pb;
  assign dout_c = pc[3];
  assign dout_r = pr[2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; start_r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        start;
    logic [17:0] base;
    logic        en;
    logic        chk_addr;
    logic [17:0] addr;
    logic        busy;
    logic        done_a;
    logic        done_b;
    logic        done_c;
  } vec_t;

  vec_t        tbl [11];
  logic [17:0] ea;
  logic [5:0]  rb;
  logic [55:0] exp_r;
  int          gap;
  int          got;

  initial begin
    tbl[0]  = '{1'b1, 18'd100, 1'b0, 1'b1, 18'd0,   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 18'd100, 1'b1, 1'b1, 18'd100, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 18'd100, 1'b1, 1'b1, 18'd101, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 18'd100, 1'b1, 1'b1, 18'd102, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 18'd100, 1'b1, 1'b1, 18'd103, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 18'd100, 1'b0, 1'b0, 18'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 18'd100, 1'b0, 1'b0, 18'd0,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 18'd100, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 18'd100, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 18'd100, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 18'd100, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1, 1'b1, 1'b1};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst mem_en", en_a, 0);
    chk("rst mem_addr", addr_a, 0);
    chk("rst data_out", data_a, 0);
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    chk("rst b/c/r idle", {busy_b, busy_c, busy_r, done_b, done_c, done_r, en_b, en_c, en_r}, 0);
    chk("rst b/c addr", {addr_b, addr_c}, 0);
`ifdef WEIGHT_LOADER_STREAM_EN
    chk("rst stream", {sv_a, sd_a, si_a, sv_b, sv_c, sv_r}, 0);
`endif
    rst = 1'b0;

    // Basic load and latency sweep, table driven
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("s1 c%0d mem_en", i), en_a, tbl[i].en);
      if (tbl[i].chk_addr) chk($sformatf("s1 c%0d mem_addr", i), addr_a, tbl[i].addr);
      chk($sformatf("s1 c%0d busy", i), busy_a, tbl[i].busy);
      chk($sformatf("s1 c%0d done L2", i), done_a, tbl[i].done_a);
      chk($sformatf("s1 c%0d done L1", i), done_b, tbl[i].done_b);
      chk($sformatf("s1 c%0d done L4", i), done_c, tbl[i].done_c);
`ifdef WEIGHT_LOADER_STREAM_EN
      chk($sformatf("s6 c%0d w_valid", i), sv_a, (i >= 4 && i <= 7));
      if (i >= 4 && i <= 7) begin
        chk($sformatf("s6 c%0d w_index", i), si_a, 3'(i - 4));
        chk($sformatf("s6 c%0d w_data", i), sd_a, 8'(100 + i - 4));
      end
`endif
      start = tbl[i].start;
      base  = tbl[i].base;
    end
    chk("s1 data L2", data_a, 32'h67666564);
    chk("s2 data L1", data_b, 32'h67666564);
    chk("s2 data L4", data_c, 32'h67666564);

    // Address wrap
    do_reset();
    @(negedge clk);
    start = 1'b1; base = 18'h3FFFE;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 4) begin
        ea = 18'h3FFFE + 18'(c - 1);
        chk($sformatf("s3 c%0d mem_addr", c), addr_a, ea);
      end
      if (c == 7) chk("s3 done", done_a, 1);
    end
    chk("s3 data L2", data_a, 32'h0100FFFE);
    chk("s3 data L1", data_b, 32'h0100FFFE);
    chk("s3 data L4", data_c, 32'h0100FFFE);

    // Start held while busy, then restart from the first DONE cycle
    do_reset();
    @(negedge clk);
    start = 1'b1; base = 18'd200;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk($sformatf("s4 c%0d mem_en", c), en_a, 1);
        chk($sformatf("s4 c%0d mem_addr", c), addr_a, 18'(200 + c - 1));
      end
      if (c >= 5 && c <= 7) chk($sformatf("s4 c%0d no reissue", c), en_a, 0);
      if (c == 7) begin
        chk("s4 done first", done_a, 1);
        chk("s4 data first", data_a, 32'hCBCAC9C8);
      end
      if (c == 8) begin
        chk("s4 restart done", done_a, 0);
        chk("s4 restart busy", busy_a, 1);
        chk("s4 restart addr", {en_a, addr_a}, {1'b1, 18'd0});
      end
      if (c == 13) chk("s4 done early", done_a, 0);
      if (c == 14) begin
        chk("s4 done second", done_a, 1);
        chk("s4 data second", data_a, 32'h03020100);
      end
      start = (c <= 4) || (c == 7);
      base  = (c >= 7) ? 18'd0 : 18'd200;
    end

    // Reset mid-load, then a fresh load
    @(negedge clk);
    start = 1'b1; base = 18'd100;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("s5 rst mem_en", en_a, 0);
        chk("s5 rst mem_addr", addr_a, 0);
        chk("s5 rst data", data_a, 0);
        chk("s5 rst done/busy", {done_a, busy_a}, 0);
      end
      if (c >= 5 && c <= 8) chk($sformatf("s5 c%0d discarded", c), {en_a, data_a}, 0);
      if (c == 14) chk("s5 done early", done_a, 0);
      if (c == 15) begin
        chk("s5 done", done_a, 1);
        chk("s5 data", data_a, 32'h35343332);
      end
      rst   = (c == 3);
      start = (c == 8);
      base  = 18'd50;
    end
    start = 1'b0;

    // Randomized runs on the 7-word instance against the model
    do_reset();
    for (int run = 0; run < 25; run++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rb = 6'($urandom);
      salt = 8'($urandom);
      base_r = rb;
      start_r = 1'b1;
      got = 0;
      for (int c = 1; c <= TR + LR + 1; c++) begin
        @(negedge clk);
        chk($sformatf("r%0d c%0d mem_en", run, c), en_r, (c <= TR));
        if (c <= TR) chk($sformatf("r%0d c%0d mem_addr", run, c), addr_r, 6'(rb + 6'(c - 1)));
        chk($sformatf("r%0d c%0d busy", run, c), busy_r, (c <= TR + LR));
        chk($sformatf("r%0d c%0d done", run, c), done_r, (c == TR + LR + 1));
`ifdef WEIGHT_LOADER_STREAM_EN
        chk($sformatf("r%0d c%0d w_valid", run, c), sv_r, (c >= LR + 2));
        if (sv_r) begin
          chk($sformatf("r%0d w_index", run), si_r, 3'(got));
          chk($sformatf("r%0d w_data", run), sd_r, f_r(rb + 6'(got), salt));
          got++;
        end
`endif
        start_r = (c < TR + LR + 1) ? 1'($urandom) : 1'b0;
        base_r  = 6'($urandom);
      end
      for (int i = 0; i < TR; i++) exp_r[i*8 +: 8] = f_r(rb + 6'(i), salt);
      chk($sformatf("r%0d data", run), data_r, exp_r);
`ifdef WEIGHT_LOADER_STREAM_EN
      chk($sformatf("r%0d stream count", run), got, TR);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_loader_stream.md
# weight_loader_stream

Parametrised BRAM-to-register weight loader for the FC-layer datapath. On `start` it reads `TOTAL_WEIGHTS` consecutive words from a shared BRAM read port, beginning at a runtime base address, and packs them into a flat weight bus for the layer MAC. Compared with the per-layer fixed loaders, it adds:

- a runtime base address;
- configurable read latency;
- synchronous reset;
- restart and busy handshaking;
- an optional streaming output.

It sits between the weight BRAM and one layer instance.

## Interface
- `IN_SIZE`, 1152, layer input count
- `OUT_SIZE`, 8, layer output count
- `W`, 8, weight word width (must equal BRAM data width)
- `TOTAL_WEIGHTS`, `IN_SIZE*OUT_SIZE`, words loaded per run (≥1)
- `ADDR_WIDTH`, 18, BRAM address width
- `RD_LATENCY`, 2, BRAM cycles from address presented to `mem_dout` valid (1..4)
- `clk` in 1: system clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: load request; sampled only in IDLE or DONE
- `base_addr` in `ADDR_WIDTH`: first BRAM address; latched when `start` is accepted
- `mem_en` out 1: BRAM enable/read-enable
- `mem_addr` out `ADDR_WIDTH`: BRAM read address
- `mem_dout` in `W`: BRAM read data
- `data_out` out `TOTAL_WEIGHTS*W`: word k at `[k*W +: W]`
- `busy` out 1: high in READ and DRAIN
- `done` out 1: high in DONE

## Operation
- **States.** IDLE, READ, DRAIN, DONE.
- **IDLE → READ** on `start`. Latch `base_addr`, clear the issue counter, the capture counter and the valid pipe.
- **READ.** Issue one read per cycle: `mem_addr = base + issued` (mod 2^`ADDR_WIDTH`, wrap allowed), `mem_en = 1`. After issue `TOTAL_WEIGHTS-1`, go to DRAIN.
- **DRAIN.** `mem_en = 0`. Wait until all outstanding reads are captured, then go to DONE.
- **Capture.** A valid pipe of depth `RD_LATENCY` tracks each issued read. When its output is high, write `mem_dout` into `data_out[captured*W +: W]` and increment `captured`.
- **Completion.** Capture count reaching `TOTAL_WEIGHTS` is the only exit condition from DRAIN. No off-by-one padding reads are issued.
- **DONE.** Hold `data_out` stable. `start` in DONE behaves like `start` in IDLE, so the next run can begin immediately.
- **`start` while busy.** Ignored; no queueing.
- **Partial results.** `data_out` is not cleared at `start`. Each word is overwritten during the run, and the bus is valid only while `done` is high.
- **`rst`.** Asserting it at any time, including mid-READ, forces IDLE. Outstanding BRAM data is discarded.
- **Counters.** Issue and capture counters are `$clog2(TOTAL_WEIGHTS+1)` bits wide.

## Timing
- **Reset values.** IDLE; `mem_en=0`, `mem_addr=0`, `data_out=0`, `busy=0`, `done=0`, and the stream outputs are 0.
- **Cycle numbering.** `start` is sampled at edge 0. In cycle c (c ≥ 1), `mem_addr = base+c-1` with `mem_en=1`, for c = 1..`TOTAL_WEIGHTS`.
- **Capture edge.** Word k is captured at the end of cycle k+1+`RD_LATENCY`.
- **Done.** `done` rises in cycle `TOTAL_WEIGHTS+RD_LATENCY+1`. Latency from `start` to `done` is `TOTAL_WEIGHTS+RD_LATENCY+1` cycles.
- **Busy.** `busy` goes high in cycle 1 and low in the same cycle `done` rises.
- **Back-to-back restart.** A `start` sampled in the first DONE cycle gives `done=0`, `busy=1` in the next cycle.

## Configuration
- **`WEIGHT_LOADER_STREAM_EN` defined.** Adds three outputs:
  - `w_valid` (1): pulses one cycle per captured word, registered, in the same cycle that word becomes visible on `data_out`.
  - `w_data` (`W`): that word.
  - `w_index` (counter width): that word's index k.
  - This lets the MAC start consuming weights before `done`.
- **Undefined.** These ports and their registers do not exist, and behaviour is otherwise identical.

## Structure
- **Package `weight_loader_pkg`.**
  - State encoding localparams: IDLE=2'b00, READ=2'b01, DRAIN=2'b10, DONE=2'b11.
  - Default `W`/`ADDR_WIDTH`.
  - Max `RD_LATENCY` constant.
- **Sub-module `rd_valid_pipe`.**
  - A `RD_LATENCY`-deep shift register of valid bits with synchronous reset and flush.
  - Its output drives the capture enable.
- **BRAM.** Stays external so that multiple loaders can time-share it through an arbiter.

## Test plan
Unless a scenario says otherwise, the bench BRAM model returns `mem_dout = addr[7:0]` after `RD_LATENCY` cycles.

1. **Basic load.** `TOTAL_WEIGHTS=4`, `RD_LATENCY=2`, `base_addr=100`.
   - `mem_addr` is 100..103 in cycles 1..4.
   - `data_out = {8'd103,8'd102,8'd101,8'd100}`.
   - `done` rises in cycle 7.
2. **Latency sweep.** Same load with `RD_LATENCY=1` and `RD_LATENCY=4`.
   - `done` rises in cycles 6 and 9 respectively.
   - `data_out` is identical to scenario 1.
3. **Address wrap.**
   - `ADDR_WIDTH=18`, `base_addr=18'h3FFFE`, `TOTAL_WEIGHTS=4`: addresses are 3FFFE, 3FFFF, 0, 1, and data is {01,00,FF,FE}.
4. **Busy/restart handshake.**
   - `start` held during READ: ignored, one run only.
   - `start` in the first DONE cycle with `base_addr=0`: `done` drops next cycle, then rises again with `data_out = {3,2,1,0}`.
5. **Reset mid-load.**
   - Assert `rst` in cycle 3: the next cycle shows IDLE, `mem_en=0`, `data_out=0`, `done=0`.
   - A new `start` afterwards loads correctly.
6. **Stream mode** (`WEIGHT_LOADER_STREAM_EN`, scenario-1 setup).
   - `w_valid` pulses in cycles 4..7.
   - `w_index` 0..3 with `w_data` 100..103.
